// File: rtl/adc_stream_capture.sv
`default_nettype none
// ============================================================================
// Module   : adc_stream_capture
// Purpose  : ADC sample-clock generator and capture front end. It divides
//            sys_clk down to ad_clk using a divider that can be changed at
//            runtime. It captures ad_digits_in on every divider-driven
//            ad_clk falling edge. Samples go into a first-word-fall-through
//            FIFO with a valid/ready output, an occupancy level and a sticky
//            overflow flag.
// Ports    : sys_clk, rst          - clock, synchronous active-high reset
//            enable                - runs the sample clock and the capture
//            div_half              - ad_clk half-period minus 1 (sys_clk cycles)
//            ad_digits_in          - ADC parallel data
//            ad_clk                - ADC sample clock
//            sample_data/valid     - FIFO head and its valid flag
//            sample_ready          - consumer pops the head when valid
//            fifo_level            - entry count, 0 .. 2^FIFO_AW
//            overflow / clear_ovf  - sticky drop flag and its clear
// Options  : ADC_AVG_EN - when defined, pushes the truncated mean of every
//            2^AVG_LOG2 captures instead of raw samples.
// Revision : 1.0 - initial release
// ============================================================================
module adc_stream_capture #(
    parameter int DATA_W      = 8,
    parameter int DIV_W       = 16,
    parameter int DIV_DEFAULT = 49,
    parameter int FIFO_AW     = 4,
    parameter int AVG_LOG2    = 2
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DIV_W-1:0]  div_half,
    input  logic [DATA_W-1:0] ad_digits_in,
    output logic              ad_clk,
    output logic [DATA_W-1:0] sample_data,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic [FIFO_AW:0]  fifo_level,
    output logic              overflow,
    input  logic              clear_ovf
);

    localparam int               c_DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] c_FULL  = (FIFO_AW + 1)'(c_DEPTH);

    // ------------------------------------------------------------------
    // Sample clock generator
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] r_div_cnt;
    logic [DIV_W-1:0] r_div_active;
    logic             r_ad_clk;
    logic             w_wrap;
    logic             w_fall;

    assign w_wrap = (r_div_cnt == r_div_active);
    // Only a divider wrap while high counts as a capture edge. A low level
    // forced by enable=0 never captures.
    assign w_fall = enable && w_wrap && r_ad_clk;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_div_cnt    <= '0;
            r_div_active <= DIV_W'(DIV_DEFAULT);
            r_ad_clk     <= 1'b0;
        end else if (!enable) begin
            r_div_cnt    <= '0;
            r_ad_clk     <= 1'b0;
            r_div_active <= div_half;
        end else if (w_wrap) begin
            // New divider values are loaded only at a half-period boundary,
            // so ad_clk cannot glitch.
            r_div_cnt    <= '0;
            r_ad_clk     <= ~r_ad_clk;
            r_div_active <= div_half;
        end else begin
            r_div_cnt    <= r_div_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Capture stage: r_cap/r_cap_vld are the pending FIFO push
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_cap;
    logic              r_cap_vld;

`ifdef ADC_AVG_EN
    logic [DATA_W+AVG_LOG2-1:0] r_acc;
    logic [AVG_LOG2-1:0]        r_avg_cnt;
    logic [DATA_W+AVG_LOG2-1:0] w_sum;

    assign w_sum = r_acc + {{AVG_LOG2{1'b0}}, ad_digits_in};

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_avg_cnt <= '0;
            r_cap     <= '0;
            r_cap_vld <= 1'b0;
        end else begin
            r_cap_vld <= 1'b0;
            if (!enable) begin
                // A partial window is discarded. An already pending push
                // is left alone and still completes.
                r_acc     <= '0;
                r_avg_cnt <= '0;
            end else if (w_fall) begin
                r_avg_cnt <= r_avg_cnt + 1'b1;
                if (r_avg_cnt == {AVG_LOG2{1'b1}}) begin
                    r_cap     <= w_sum[DATA_W+AVG_LOG2-1 -: DATA_W];
                    r_cap_vld <= 1'b1;
                    r_acc     <= '0;
                end else begin
                    r_acc     <= w_sum;
                end
            end
        end
    end
`else
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_cap     <= '0;
            r_cap_vld <= 1'b0;
        end else begin
            r_cap_vld <= w_fall;
            if (w_fall) begin
                r_cap <= ad_digits_in;
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // FWFT FIFO. The head is kept in r_data/r_valid, which are prefetched
    // from the memory state before the current edge. A push into an empty
    // FIFO therefore shows up one cycle after the write.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]  r_mem [c_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_level;
    logic [DATA_W-1:0]  r_data;
    logic               r_valid;
    logic               r_ovf;

    logic               w_pop;
    logic               w_full;
    logic               w_push;
    logic               w_drop;
    logic [FIFO_AW-1:0] w_rd_next;
    logic [FIFO_AW:0]   w_remain;

    assign w_pop     = r_valid && sample_ready;
    assign w_full    = (r_level == c_FULL);
    // When the FIFO is full, a simultaneous pop frees the slot the push uses.
    assign w_push    = r_cap_vld && (!w_full || w_pop);
    assign w_drop    = r_cap_vld && w_full && !w_pop;
    assign w_rd_next = r_rd_ptr + {{(FIFO_AW-1){1'b0}}, w_pop};
    // These are the entries already stored that survive this edge. They are
    // the only entries whose data can be read from r_mem right now.
    assign w_remain  = r_level - {{FIFO_AW{1'b0}}, w_pop};

    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_cap;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr <= w_rd_next;
            r_level  <= r_level + {{FIFO_AW{1'b0}}, w_push}
                                - {{FIFO_AW{1'b0}}, w_pop};
            r_valid  <= (w_remain != '0);
            if (w_remain != '0) begin
                r_data <= r_mem[w_rd_next];
            end
            // Set takes priority over clear.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clear_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign ad_clk       = r_ad_clk;
    assign sample_data  = r_data;
    assign sample_valid = r_valid;
    assign fifo_level   = r_level;
    assign overflow     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_adc_stream_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_stream_capture
// Purpose  : Self-checking bench for adc_stream_capture. A cycle model of
//            the divider and capture path pushes the expected samples into a
//            scoreboard queue. The queue is popped and compared on each DUT
//            handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_stream_capture;

    localparam int DATA_W   = 8;
    localparam int DIV_W    = 16;
    localparam int FIFO_AW  = 4;
    localparam int AVG_LOG2 = 2;

    logic              sys_clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic [DIV_W-1:0]  div_half = 16'd49;
    logic [DATA_W-1:0] ad_digits_in = '0;
    logic              ad_clk;
    logic [DATA_W-1:0] sample_data;
    logic              sample_valid;
    logic              sample_ready = 1'b0;
    logic [FIFO_AW:0]  fifo_level;
    logic              overflow;
    logic              clear_ovf = 1'b0;

    adc_stream_capture #(
        .DATA_W     (DATA_W),
        .DIV_W      (DIV_W),
        .DIV_DEFAULT(49),
        .FIFO_AW    (FIFO_AW),
        .AVG_LOG2   (AVG_LOG2)
    ) u_dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .enable      (enable),
        .div_half    (div_half),
        .ad_digits_in(ad_digits_in),
        .ad_clk      (ad_clk),
        .sample_data (sample_data),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .clear_ovf   (clear_ovf)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model and scoreboard, evaluated on every rising edge
    // ------------------------------------------------------------------
    int  cyc = 0;
    int  m_cnt, m_div, m_level, m_pend_data, m_acc, m_navg;
    bit  m_clk, m_pend, m_ovf;
    int  m_pends = 0;
    int  last_fall = -100;
    int  q[$];
    bit  prev_valid = 1'b0;
    int  prev_data = 0;
    bit  chk_lat = 1'b0;
    bit  ramp_en = 1'b0;

    int  s_div, s_din;
    bit  s_rst, s_en, s_rdy, s_clr, s_pop, s_full, s_drop;

    always begin
        @(posedge sys_clk);
        cyc++;
        s_rst = rst;   s_en = enable; s_div = int'(div_half);
        s_din = int'(ad_digits_in); s_rdy = sample_ready; s_clr = clear_ovf;
        if (s_rst) begin
            m_cnt = 0; m_div = 49; m_clk = 0; m_pend = 0; m_level = 0;
            m_ovf = 0; m_acc = 0; m_navg = 0;
            q.delete();
        end else begin
            s_pop  = prev_valid && s_rdy;
            s_full = (m_level == (1 << FIFO_AW));
            if (s_pop) begin
                if (q.size() == 0) check_eq("pop_has_entry", q.size(), 1);
                else               check_eq("pop_data", prev_data, q.pop_front());
                m_level--;
            end
            s_drop = 0;
            if (m_pend) begin
                if (s_full && !s_pop) s_drop = 1;
                else begin
                    q.push_back(m_pend_data);
                    m_level++;
                end
            end
            if (s_drop)     m_ovf = 1;
            else if (s_clr) m_ovf = 0;
            m_pend = 0;
            if (!s_en) begin
                m_cnt = 0; m_clk = 0; m_div = s_div; m_acc = 0; m_navg = 0;
            end else if (m_cnt == m_div) begin
                if (m_clk) begin
`ifdef ADC_AVG_EN
                    m_acc += s_din;
                    m_navg++;
                    if (m_navg == (1 << AVG_LOG2)) begin
                        m_pend = 1; m_pend_data = m_acc >> AVG_LOG2;
                        m_acc = 0; m_navg = 0; m_pends++; last_fall = cyc;
                    end
`else
                    m_pend = 1; m_pend_data = s_din; m_pends++; last_fall = cyc;
`endif
                end
                m_clk = !m_clk; m_cnt = 0; m_div = s_div;
            end else begin
                m_cnt++;
            end
        end
        #1;
        check_eq("ad_clk", ad_clk, m_clk);
        check_eq("fifo_level", fifo_level, m_level);
        check_eq("overflow", overflow, m_ovf);
        check_eq("valid_while_empty", sample_valid && (m_level == 0), 0);
        if (chk_lat && sample_valid && !prev_valid)
            check_eq("valid_latency", cyc - last_fall, 2);
        prev_valid = sample_valid;
        prev_data  = int'(sample_data);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all input changes happen on the falling edge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(negedge sys_clk);
        if (ramp_en) ad_digits_in = cyc[7:0];
    endtask

    task automatic measure_level(input bit lvl, output int n);
        n = 0;
        while (ad_clk === lvl && n < 2000) begin
            tick();
            n++;
        end
    endtask

`ifdef ADC_AVG_EN
    task automatic feed(input int v);
        int g;
        g = 0;
        while (!(enable && m_clk && m_cnt == m_div) && g < 200) begin
            tick();
            g++;
        end
        check_eq("feed_bound", g < 200, 1);
        ad_digits_in = DATA_W'(v);
        tick();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int n, g, f0;
        // Reset: held with enable high
        rst = 1; enable = 1; div_half = 16'd49;
        repeat (3) tick();
        check_eq("rst_ad_clk", ad_clk, 0);
        check_eq("rst_valid", sample_valid, 0);
        check_eq("rst_level", fifo_level, 0);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_data", sample_data, 0);
        rst = 0;

        // First rise and divider periods
        n = 0;
        while (!ad_clk && n < 1000) begin
            tick();
            n++;
        end
        check_eq("first_rise_cycle", n, 50);
        measure_level(1, n);
        check_eq("high_49", n, 50);
        repeat (10) tick();
        div_half = 16'd4;
        measure_level(0, n);
        check_eq("low_after_div_write", n + 10, 50);
        measure_level(1, n);
        check_eq("high_4", n, 5);
        measure_level(0, n);
        check_eq("low_4", n, 5);

        // Capture latency with a ramp on the data bus
        div_half = 16'd1;
        ramp_en = 1;
        sample_ready = 1;
        repeat (20) tick();
        chk_lat = 1;
        repeat (80) tick();
        chk_lat = 0;

        // Overflow: 17 pushes with no consumer
        sample_ready = 0;
        f0 = m_pends;
        g = 0;
        while (m_pends < f0 + 17 && g < 2000) begin
            tick();
            g++;
        end
        repeat (2) tick();
        check_eq("full_level", fifo_level, 16);
        check_eq("full_overflow", overflow, 1);
        enable = 0;
        repeat (3) tick();
        clear_ovf = 1;
        tick();
        clear_ovf = 0;
        check_eq("ovf_cleared", overflow, 0);
        check_eq("level_kept_disabled", fifo_level, 16);

        // Full FIFO with a pop on the push cycle
        enable = 1;
        g = 0;
        while (!m_pend && g < 200) begin
            tick();
            g++;
        end
        check_eq("push_seen", m_pend, 1);
        sample_ready = 1;
        tick();
        sample_ready = 0;
        enable = 0;
        check_eq("full_pop_push_level", fifo_level, 16);
        check_eq("full_pop_push_ovf", overflow, 0);

        // Drain: scoreboard checks order and contents
        sample_ready = 1;
        g = 0;
        while ((fifo_level != 0 || sample_valid) && g < 200) begin
            tick();
            g++;
        end
        check_eq("drained_level", fifo_level, 0);
        check_eq("queue_drained", q.size(), 0);
        ramp_en = 0;

`ifdef ADC_AVG_EN
        // Averaging: one window, then a discarded partial window, then one
        // more full window
        sample_ready = 0;
        enable = 1;
        feed(10); feed(11); feed(12); feed(14);
        repeat (3) tick();
        check_eq("avg_level_1", fifo_level, 1);
        check_eq("avg_value_1", sample_data, 11);
        feed(50); feed(60);
        enable = 0;
        repeat (3) tick();
        enable = 1;
        feed(20); feed(20); feed(24); feed(24);
        repeat (3) tick();
        enable = 0;
        check_eq("avg_level_2", fifo_level, 2);
        sample_ready = 1;
        repeat (6) tick();
        check_eq("avg_queue_drained", q.size(), 0);
`endif

        repeat (4) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_stream_capture.md
Name: adc_stream_capture

Overview:
- Parametrised successor to the team's fixed 1 MHz ADC front end.
- Generates the ADC sample clock from sys_clk with a runtime-programmable divider and captures parallel ADC data on each ad_clk falling edge.
- Buffers samples in a first-word-fall-through FIFO with a valid/ready output, level and sticky overflow flag.
- Sits between the external ADC pins and the trigger/display pipeline.

Parameters:
- DATA_W, 8, ADC data width.
- DIV_W, 16, width of the divider half-period register.
- DIV_DEFAULT, 49, divider value loaded at reset (100 MHz / 100 = 1 MHz).
- FIFO_AW, 4, FIFO address width; depth = 2^FIFO_AW = 16.
- AVG_LOG2, 2, log2 of the averaging window; used only with ADC_AVG_EN.

Ports:
- sys_clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  runs the sample clock and capture when high.
- div_half  in  DIV_W  ad_clk half-period minus 1, in sys_clk cycles.
- ad_digits_in  in  DATA_W  ADC parallel data.
- ad_clk  out  1  ADC sample clock.
- sample_data  out  DATA_W  FIFO head.
- sample_valid  out  1  FIFO not empty.
- sample_ready  in  1  consumer accepts the head on this cycle.
- fifo_level  out  FIFO_AW+1  current entry count, 0..16.
- overflow  out  1  sticky flag: a sample was dropped.
- clear_ovf  in  1  clears overflow.

Behaviour:
- Reset: ad_clk=0, divider counter=0, active divider=DIV_DEFAULT, sample_valid=0, fifo_level=0, overflow=0, sample_data=0, capture register=0, accumulator=0.
- Clock generator:
  - Counter increments each cycle while enable=1.
  - When counter == active divider: counter goes to 0, ad_clk toggles, and div_half is loaded as the new active divider.
  - div_half changes therefore take effect only at a half-period boundary; ad_clk never glitches.
  - div_half=0 gives ad_clk = sys_clk/2.
- enable=0: counter held at 0 and ad_clk forced to 0 on the next edge. div_half is loaded continuously while disabled. A falling edge forced by disable is not a capture edge.
- Capture:
  - On the sys_clk edge where ad_clk goes 1->0 by divider wrap, ad_digits_in is registered into the capture register.
  - The sample is pushed into the FIFO on the next edge.
  - sample_valid rises 2 cycles after the ad_clk falling edge when the FIFO was empty.
- FIFO:
  - First-word-fall-through: sample_data shows the oldest entry whenever sample_valid=1.
  - Pop occurs when sample_valid && sample_ready.
  - sample_data holds its last value when the FIFO is empty.
- Simultaneous push and pop: level unchanged. This holds when full too: the pop frees a slot and the push is accepted.
- Push when full with no pop: the sample is dropped, FIFO contents are unchanged, and overflow is set.
- overflow clears on clear_ovf. If clear_ovf and a drop occur in the same cycle, set wins.
- Pointers wrap modulo 2^FIFO_AW. fifo_level saturates by construction at 2^FIFO_AW.
- Deasserting enable mid-operation: FIFO contents and any pending push are retained and completed; draining continues normally.

Optional Feature:
- Macro: ADC_AVG_EN.
- Defined:
  - Captures accumulate in a DATA_W+AVG_LOG2-bit accumulator.
  - After every 2^AVG_LOG2 captures, accumulator >> AVG_LOG2 (truncating) is pushed one cycle later and the accumulator resets to 0.
  - enable=0 discards a partial window.
  - Overflow rules apply to averaged pushes.
- Undefined: every capture is pushed raw; no accumulator logic is present.

Test Plan:
- Reset: hold rst=1 for 3 cycles with enable=1 -> ad_clk=0, sample_valid=0, fifo_level=0, overflow=0; after release, first ad_clk rise occurs at cycle 50 with div_half=49.
- Divider: div_half=49 -> ad_clk period 100 cycles, 50 high. Write div_half=4 mid half-period -> current half finishes at 50 cycles, then period is 10.
- Capture latency: div_half=1, ad_digits_in = cycle-count ramp, sample_ready=1 -> each popped value equals the input at the ad_clk falling edge; sample_valid rises 2 cycles after each fall.
- Overflow: sample_ready=0, 17 captures -> fifo_level=16, overflow=1, draining yields the first 16 values in order. Then pulse clear_ovf -> overflow=0.
- Full with simultaneous pop: level=16, sample_ready=1 on a push cycle -> level stays 16, the new sample lands at the tail, overflow stays 0.
- ADC_AVG_EN with AVG_LOG2=2: captured inputs 10, 11, 12, 14 -> one FIFO entry of 11 (47>>2). Disable after 2 captures -> no entry; next full window averages fresh samples.
